// File: rtl/beta_trap_pkg.sv
// Shared types and cause codes for the beta trap sequencer.
// Imported by beta_trap_sequencer and beta_irq_prio_encoder.
package beta_trap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      COMMIT,
      REDIRECT
   } trap_fsm_e;

   typedef enum logic [1:0] {
      KIND_EXC,
      KIND_IRQ,
      KIND_MRET
   } trap_kind_e;

   localparam int unsigned MSW_INT        = 3;
   localparam int unsigned MTIM_INT       = 7;
   localparam int unsigned MEXT_INT       = 11;
   localparam int unsigned LOCAL_INT_BASE = 16;

   localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
   localparam logic [4:0] EXC_INSTR_ACCESS   = 5'd1;
   localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
   localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
   localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] EXC_LOAD_ACCESS    = 5'd5;
   localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] EXC_STORE_ACCESS   = 5'd7;
   localparam logic [4:0] EXC_ECALL_U        = 5'd8;
   localparam logic [4:0] EXC_ECALL_M        = 5'd11;

   // Cause code of local interrupt line idx.
   function automatic logic [4:0] local_cause(input int unsigned idx);
      return 5'(LOCAL_INT_BASE + idx);
   endfunction

endpackage

// File: rtl/beta_irq_prio_encoder.sv
// Combinational interrupt priority encoder: MEI > MSI > MTI > local lines
// (highest index first). Input is the already-masked pending vector.
module beta_irq_prio_encoder
   import beta_trap_pkg::*;
#(
   parameter int unsigned NumLocalIrq = 16
) (
   input  logic [LOCAL_INT_BASE+NumLocalIrq-1:0] pending_i,
   output logic                                  irq_valid_o,
   output logic [4:0]                            irq_cause_o
);

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      irq_valid_o = 1'b0;
      irq_cause_o = '0;
      // Walk from lowest to highest priority; later hits override earlier ones.
      for (int i = 0; i < int'(NumLocalIrq); i++) begin
         if (pending_i[LOCAL_INT_BASE+i]) begin
            irq_valid_o = 1'b1;
            irq_cause_o = local_cause(i);
         end
      end
      if (pending_i[MTIM_INT]) begin
         irq_valid_o = 1'b1;
         irq_cause_o = 5'(MTIM_INT);
      end
      if (pending_i[MSW_INT]) begin
         irq_valid_o = 1'b1;
         irq_cause_o = 5'(MSW_INT);
      end
      if (pending_i[MEXT_INT]) begin
         irq_valid_o = 1'b1;
         irq_cause_o = 5'(MEXT_INT);
      end
   end

   logic unused_std_bits;
   assign unused_std_bits = ^{pending_i[15:12], pending_i[10:8], pending_i[6:4], pending_i[2:0]};

endmodule

// File: rtl/beta_trap_sequencer.sv
// Multi-cycle trap sequencer: pending-interrupt registers, event arbitration and the
// FLUSH -> COMMIT -> REDIRECT handshake. Define BETA_TRAP_VECTORED_EN for vectored mtvec.
module beta_trap_sequencer
   import beta_trap_pkg::*;
#(
   parameter int unsigned             DataWidth    = 32,
   parameter int unsigned             AddrWidth    = 32,
   parameter int unsigned             NumLocalIrq  = 16,
   parameter logic [NumLocalIrq-1:0]  LocalIrqEdge = '0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 priv_lvl_i,
   input  logic                                 exc_valid_i,
   input  logic [4:0]                           exc_cause_i,
   input  logic [DataWidth-1:0]                 exc_tval_i,
   input  logic [AddrWidth-1:0]                 exc_pc_i,
   input  logic                                 mret_i,
   input  logic                                 irq_allow_i,
   input  logic [AddrWidth-1:0]                 boundary_pc_i,
   input  logic                                 sw_irq_i,
   input  logic                                 tim_irq_i,
   input  logic                                 ext_irq_i,
   input  logic [NumLocalIrq-1:0]               local_irq_i,
   input  logic [NumLocalIrq-1:0]               irq_clear_i,
   input  logic                                 mstatus_mie_i,
   input  logic                                 mstatus_mpie_i,
   input  logic                                 mstatus_mpp_i,
   input  logic [LOCAL_INT_BASE+NumLocalIrq-1:0] mie_en_i,
   input  logic [AddrWidth-1:0]                 mtvec_i,
   input  logic [AddrWidth-1:0]                 mepc_i,
   input  logic                                 pipe_idle_i,
   output logic                                 flush_o,
   output logic                                 csr_we_o,
   output logic [DataWidth-1:0]                 mcause_o,
   output logic [AddrWidth-1:0]                 mepc_o,
   output logic [DataWidth-1:0]                 mtval_o,
   output logic [2:0]                           trap_state_o,
   output logic                                 priv_o,
   output logic [LOCAL_INT_BASE+NumLocalIrq-1:0] mip_o,
   output logic                                 redirect_valid_o,
   output logic [AddrWidth-1:0]                 redirect_pc_o,
   input  logic                                 redirect_ready_i,
   output logic                                 busy_o
);

   localparam int unsigned IrqW = LOCAL_INT_BASE + NumLocalIrq;

   trap_fsm_e             state_q;
   trap_kind_e            kind_q;
   logic [4:0]            cause_q;
   logic [DataWidth-1:0]  tval_q;
   logic [AddrWidth-1:0]  epc_q;
   logic [AddrWidth-1:0]  target_q;
   logic [2:0]            tstate_q;
   logic                  priv_q;

   logic [IrqW-1:0]        mip_q;
   logic [IrqW-1:0]        mip_d;
   logic [NumLocalIrq-1:0] local_q;
   logic                   commit_irq;

   // ---------------------------------------------------------------- pending bits
   assign commit_irq = (state_q == COMMIT) && (kind_q == KIND_IRQ);

   always_comb begin
      mip_d           = '0;
      mip_d[MSW_INT]  = sw_irq_i;
      mip_d[MTIM_INT] = tim_irq_i;
      mip_d[MEXT_INT] = ext_irq_i;
      for (int i = 0; i < int'(NumLocalIrq); i++) begin
         if (LocalIrqEdge[i]) begin
            // A fresh rising edge wins over a clear landing in the same cycle.
            mip_d[LOCAL_INT_BASE+i] = (local_irq_i[i] & ~local_q[i])
                                    | (mip_q[LOCAL_INT_BASE+i] & ~irq_clear_i[i]
                                       & ~(commit_irq && (cause_q == local_cause(i))));
         end else begin
            mip_d[LOCAL_INT_BASE+i] = local_irq_i[i];
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mip_q   <= '0;
         local_q <= '0;
      end else begin
         mip_q   <= mip_d;
         local_q <= local_irq_i;
      end
   end

   assign mip_o = mip_q;

   // ---------------------------------------------------------------- arbitration
   logic [IrqW-1:0] irq_masked;
   logic            irq_valid;
   logic [4:0]      irq_cause;
   logic            irq_take;
   logic            event_go;

   assign irq_masked = mip_q & mie_en_i;

   beta_irq_prio_encoder #(
      .NumLocalIrq (NumLocalIrq)
   ) u_prio (
      .pending_i   (irq_masked),
      .irq_valid_o (irq_valid),
      .irq_cause_o (irq_cause)
   );

   assign irq_take = mstatus_mie_i & irq_allow_i & irq_valid;
   assign event_go = mret_i | exc_valid_i | irq_take;

   logic [AddrWidth-1:0] trap_base;
   logic [AddrWidth-1:0] irq_target;

   assign trap_base = {mtvec_i[AddrWidth-1:2], 2'b00};

`ifdef BETA_TRAP_VECTORED_EN
   assign irq_target = (mtvec_i[1:0] == 2'b01)
                     ? trap_base + (AddrWidth'(irq_cause) << 2)
                     : trap_base;
`else
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_i[1:0];
   assign irq_target        = trap_base;
`endif

   // MRET leaves mcause untouched, so it presents zero on the CSR bus.
   logic [DataWidth-1:0] mcause_d;

   always_comb begin
      mcause_d                = DataWidth'(cause_q);
      mcause_d[DataWidth-1]   = (kind_q == KIND_IRQ);
      if (kind_q == KIND_MRET) begin
         mcause_d = '0;
      end
   end

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= IDLE;
         kind_q           <= KIND_EXC;
         cause_q          <= '0;
         tval_q           <= '0;
         epc_q            <= '0;
         target_q         <= '0;
         tstate_q         <= '0;
         priv_q           <= 1'b0;
         flush_o          <= 1'b0;
         csr_we_o         <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
         mcause_o         <= '0;
         mepc_o           <= '0;
         mtval_o          <= '0;
         trap_state_o     <= '0;
         priv_o           <= 1'b0;
      end else begin
         flush_o          <= 1'b0;
         csr_we_o         <= 1'b0;
         redirect_valid_o <= 1'b0;

         case (state_q)
            IDLE: begin
               if (event_go) begin
                  state_q <= FLUSH;
                  flush_o <= 1'b1;
                  if (mret_i) begin
                     kind_q   <= KIND_MRET;
                     cause_q  <= '0;
                     tval_q   <= '0;
                     epc_q    <= mepc_i;
                     target_q <= mepc_i;
                     tstate_q <= {mstatus_mpie_i, 1'b1, 1'b0};
                     priv_q   <= mstatus_mpp_i;
                  end else if (exc_valid_i) begin
                     kind_q   <= KIND_EXC;
                     cause_q  <= exc_cause_i;
                     tval_q   <= exc_tval_i;
                     epc_q    <= exc_pc_i;
                     target_q <= trap_base;
                     tstate_q <= {1'b0, mstatus_mie_i, priv_lvl_i};
                     priv_q   <= 1'b1;
                  end else begin
                     kind_q   <= KIND_IRQ;
                     cause_q  <= irq_cause;
                     tval_q   <= '0;
                     epc_q    <= boundary_pc_i;
                     target_q <= irq_target;
                     tstate_q <= {1'b0, mstatus_mie_i, priv_lvl_i};
                     priv_q   <= 1'b1;
                  end
               end
            end

            FLUSH: begin
               if (pipe_idle_i) begin
                  state_q      <= COMMIT;
                  csr_we_o     <= 1'b1;
                  mcause_o     <= mcause_d;
                  mepc_o       <= epc_q;
                  mtval_o      <= tval_q;
                  trap_state_o <= tstate_q;
                  priv_o       <= priv_q;
               end else begin
                  flush_o <= 1'b1;
               end
            end

            COMMIT: begin
               state_q          <= REDIRECT;
               redirect_valid_o <= 1'b1;
               redirect_pc_o    <= target_q;
            end

            REDIRECT: begin
               if (redirect_ready_i) begin
                  state_q       <= IDLE;
                  redirect_pc_o <= '0;
                  mcause_o      <= '0;
                  mepc_o        <= '0;
                  mtval_o       <= '0;
                  trap_state_o  <= '0;
                  priv_o        <= 1'b0;
               end else begin
                  redirect_valid_o <= 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_beta_trap_sequencer.sv
// Scoreboard bench for beta_trap_sequencer: directed stimulus pushes expected commits,
// a negedge monitor pops them on csr_we_o and checks the redirect handshake.
module tb_beta_trap_sequencer;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NL = 16;
   localparam int IW = 16 + NL;

`ifdef BETA_TRAP_VECTORED_EN
   localparam logic [31:0] MEI_VEC_TGT = 32'h0000_802C;
   localparam logic [31:0] L5_VEC_TGT  = 32'h0000_8054;
`else
   localparam logic [31:0] MEI_VEC_TGT = 32'h0000_8000;
   localparam logic [31:0] L5_VEC_TGT  = 32'h0000_8000;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          priv_lvl_i;
   logic          exc_valid_i;
   logic [4:0]    exc_cause_i;
   logic [DW-1:0] exc_tval_i;
   logic [AW-1:0] exc_pc_i;
   logic          mret_i;
   logic          irq_allow_i;
   logic [AW-1:0] boundary_pc_i;
   logic          sw_irq_i, tim_irq_i, ext_irq_i;
   logic [NL-1:0] local_irq_i;
   logic [NL-1:0] irq_clear_i;
   logic          mstatus_mie_i, mstatus_mpie_i, mstatus_mpp_i;
   logic [IW-1:0] mie_en_i;
   logic [AW-1:0] mtvec_i;
   logic [AW-1:0] mepc_i;
   logic          pipe_idle_i;
   logic          flush_o;
   logic          csr_we_o;
   logic [DW-1:0] mcause_o;
   logic [AW-1:0] mepc_o;
   logic [DW-1:0] mtval_o;
   logic [2:0]    trap_state_o;
   logic          priv_o;
   logic [IW-1:0] mip_o;
   logic          redirect_valid_o;
   logic [AW-1:0] redirect_pc_o;
   logic          redirect_ready_i;
   logic          busy_o;

   beta_trap_sequencer #(
      .DataWidth    (DW),
      .AddrWidth    (AW),
      .NumLocalIrq  (NL),
      .LocalIrqEdge (16'h0020)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .priv_lvl_i       (priv_lvl_i),
      .exc_valid_i      (exc_valid_i),
      .exc_cause_i      (exc_cause_i),
      .exc_tval_i       (exc_tval_i),
      .exc_pc_i         (exc_pc_i),
      .mret_i           (mret_i),
      .irq_allow_i      (irq_allow_i),
      .boundary_pc_i    (boundary_pc_i),
      .sw_irq_i         (sw_irq_i),
      .tim_irq_i        (tim_irq_i),
      .ext_irq_i        (ext_irq_i),
      .local_irq_i      (local_irq_i),
      .irq_clear_i      (irq_clear_i),
      .mstatus_mie_i    (mstatus_mie_i),
      .mstatus_mpie_i   (mstatus_mpie_i),
      .mstatus_mpp_i    (mstatus_mpp_i),
      .mie_en_i         (mie_en_i),
      .mtvec_i          (mtvec_i),
      .mepc_i           (mepc_i),
      .pipe_idle_i      (pipe_idle_i),
      .flush_o          (flush_o),
      .csr_we_o         (csr_we_o),
      .mcause_o         (mcause_o),
      .mepc_o           (mepc_o),
      .mtval_o          (mtval_o),
      .trap_state_o     (trap_state_o),
      .priv_o           (priv_o),
      .mip_o            (mip_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .redirect_ready_i (redirect_ready_i),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] mcause;
      logic [31:0] mepc;
      logic [31:0] mtval;
      logic [2:0]  ts;
      logic        priv;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   logic [31:0] exp_pc;
   bit          redir_pending = 1'b0;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic expect_commit(input logic [31:0] mcause, input logic [31:0] mepc,
                                input logic [31:0] mtval, input logic [2:0] ts,
                                input logic priv, input logic [31:0] pc);
      exp_t e;
      e.mcause = mcause;
      e.mepc   = mepc;
      e.mtval  = mtval;
      e.ts     = ts;
      e.priv   = priv;
      e.pc     = pc;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 100) begin
         tick();
         n++;
      end
      check("idle_reached", {63'd0, busy_o}, 64'd0);
   endtask

   // Monitor: compares every CSR commit and every accepted redirect.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (csr_we_o) begin
            if (sb_q.size() == 0) begin
               check("commit_unexpected", {63'd0, csr_we_o}, 64'd0);
            end else begin
               cur = sb_q.pop_front();
               check("mcause", {32'd0, mcause_o}, {32'd0, cur.mcause});
               check("mepc", {32'd0, mepc_o}, {32'd0, cur.mepc});
               check("mtval", {32'd0, mtval_o}, {32'd0, cur.mtval});
               check("trap_state", {61'd0, trap_state_o}, {61'd0, cur.ts});
               check("priv", {63'd0, priv_o}, {63'd0, cur.priv});
               exp_pc        = cur.pc;
               redir_pending = 1'b1;
            end
         end
         if (redirect_valid_o && redirect_ready_i) begin
            if (redir_pending) begin
               check("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, exp_pc});
               redir_pending = 1'b0;
            end else begin
               check("redirect_unexpected", {63'd0, redirect_valid_o}, 64'd0);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1;
      priv_lvl_i = 1'b1;
      exc_valid_i = 1'b0;
      exc_cause_i = '0;
      exc_tval_i = '0;
      exc_pc_i = '0;
      mret_i = 1'b0;
      irq_allow_i = 1'b0;
      boundary_pc_i = 32'h0000_0400;
      sw_irq_i = 1'b0;
      tim_irq_i = 1'b0;
      ext_irq_i = 1'b0;
      local_irq_i = '0;
      irq_clear_i = '0;
      mstatus_mie_i = 1'b0;
      mstatus_mpie_i = 1'b0;
      mstatus_mpp_i = 1'b0;
      mie_en_i = '0;
      mtvec_i = 32'h0000_8000;
      mepc_i = '0;
      pipe_idle_i = 1'b1;
      redirect_ready_i = 1'b1;

      // Reset state
      repeat (2) tick();
      rst_i = 1'b0;
      check("rst_flush", {63'd0, flush_o}, 64'd0);
      check("rst_csr_we", {63'd0, csr_we_o}, 64'd0);
      check("rst_redirect", {63'd0, redirect_valid_o}, 64'd0);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_mip", {32'd0, mip_o}, 64'd0);
      check("rst_mcause", {32'd0, mcause_o}, 64'd0);

      // Illegal instruction, minimum latency
      expect_commit(32'd2, 32'h100, 32'h13, 3'b001, 1'b1, 32'h8000);
      exc_valid_i = 1'b1;
      exc_cause_i = 5'd2;
      exc_tval_i  = 32'h0000_0013;
      exc_pc_i    = 32'h0000_0100;
      tick();
      exc_valid_i = 1'b0;
      check("ill_flush_n1", {63'd0, flush_o}, 64'd1);
      check("ill_csrwe_n1", {63'd0, csr_we_o}, 64'd0);
      tick();
      check("ill_csrwe_n2", {63'd0, csr_we_o}, 64'd1);
      check("ill_flush_n2", {63'd0, flush_o}, 64'd0);
      tick();
      check("ill_redir_n3", {63'd0, redirect_valid_o}, 64'd1);
      wait_idle();
      check("ill_mcause_cleared", {32'd0, mcause_o}, 64'd0);

      // Vectored MEI
      mtvec_i       = 32'h0000_8001;
      mstatus_mie_i = 1'b1;
      irq_allow_i   = 1'b1;
      mie_en_i      = 32'h0000_0800;
      expect_commit(32'h8000_000B, 32'h400, 32'h0, 3'b011, 1'b1, MEI_VEC_TGT);
      ext_irq_i = 1'b1;
      tick();
      check("mei_mip_visible", {63'd0, mip_o[11]}, 64'd1);
      check("mei_not_yet_taken", {63'd0, busy_o}, 64'd0);
      tick();
      check("mei_flush", {63'd0, flush_o}, 64'd1);
      ext_irq_i = 1'b0;
      mie_en_i  = '0;
      wait_idle();

      // Exception beats a same-cycle MEI; MEI is taken after MRET re-enables MIE
      mtvec_i     = 32'h0000_8000;
      irq_allow_i = 1'b0;
      mie_en_i    = 32'h0000_0800;
      ext_irq_i   = 1'b1;
      tick();
      expect_commit(32'd8, 32'h300, 32'h0, 3'b011, 1'b1, 32'h8000);
      exc_valid_i = 1'b1;
      exc_cause_i = 5'd8;
      exc_tval_i  = '0;
      exc_pc_i    = 32'h0000_0300;
      irq_allow_i = 1'b1;
      tick();
      exc_valid_i   = 1'b0;
      mstatus_mie_i = 1'b0;
      check("prio_flush", {63'd0, flush_o}, 64'd1);
      wait_idle();
      expect_commit(32'h0, 32'h304, 32'h0, 3'b110, 1'b1, 32'h304);
      mret_i         = 1'b1;
      mstatus_mpie_i = 1'b1;
      mstatus_mpp_i  = 1'b1;
      mepc_i         = 32'h0000_0304;
      tick();
      mret_i = 1'b0;
      wait_idle();
      expect_commit(32'h8000_000B, 32'h400, 32'h0, 3'b011, 1'b1, 32'h8000);
      mstatus_mie_i = 1'b1;
      tick();
      check("mei_after_mret_flush", {63'd0, flush_o}, 64'd1);
      ext_irq_i = 1'b0;
      mie_en_i  = '0;
      wait_idle();

      // Edge-mode local line 5
      mtvec_i        = 32'h0000_8001;
      local_irq_i[5] = 1'b1;
      tick();
      local_irq_i[5] = 1'b0;
      repeat (2) tick();
      check("l5_pending_held", {63'd0, mip_o[21]}, 64'd1);
      check("l5_masked_idle", {63'd0, busy_o}, 64'd0);
      expect_commit(32'h8000_0015, 32'h400, 32'h0, 3'b011, 1'b1, L5_VEC_TGT);
      mie_en_i[21] = 1'b1;
      tick();
      check("l5_flush", {63'd0, flush_o}, 64'd1);
      tick();
      check("l5_commit_mip", {63'd0, mip_o[21]}, 64'd1);
      tick();
      check("l5_cleared_after_commit", {63'd0, mip_o[21]}, 64'd0);
      mie_en_i[21] = 1'b0;
      wait_idle();

      // Software clear, and set winning over a same-cycle clear
      local_irq_i[5] = 1'b1;
      tick();
      local_irq_i[5] = 1'b0;
      tick();
      irq_clear_i[5] = 1'b1;
      tick();
      irq_clear_i[5] = 1'b0;
      check("l5_sw_clear", {63'd0, mip_o[21]}, 64'd0);
      local_irq_i[5] = 1'b1;
      irq_clear_i[5] = 1'b1;
      tick();
      local_irq_i[5] = 1'b0;
      irq_clear_i[5] = 1'b0;
      check("l5_set_wins", {63'd0, mip_o[21]}, 64'd1);
      irq_clear_i[5] = 1'b1;
      tick();
      irq_clear_i[5] = 1'b0;
      check("l5_clear_again", {63'd0, mip_o[21]}, 64'd0);

      // Level-mode local line 2 follows its input
      local_irq_i[2] = 1'b1;
      tick();
      check("l2_level_set", {63'd0, mip_o[18]}, 64'd1);
      local_irq_i[2] = 1'b0;
      tick();
      check("l2_level_clr", {63'd0, mip_o[18]}, 64'd0);

      // MRET to U-mode with redirect back-pressure
      mstatus_mie_i    = 1'b0;
      mstatus_mpie_i   = 1'b1;
      mstatus_mpp_i    = 1'b0;
      mepc_i           = 32'h0000_0200;
      redirect_ready_i = 1'b0;
      expect_commit(32'h0, 32'h200, 32'h0, 3'b110, 1'b0, 32'h200);
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         check("mret_hold_valid", {63'd0, redirect_valid_o}, 64'd1);
         check("mret_hold_pc", {32'd0, redirect_pc_o}, 64'h200);
         tick();
      end
      check("mret_hold_ts", {61'd0, trap_state_o}, 64'd6);
      redirect_ready_i = 1'b1;
      wait_idle();

      // Reset during FLUSH aborts without a CSR write
      pipe_idle_i    = 1'b0;
      local_irq_i[2] = 1'b1;
      exc_valid_i    = 1'b1;
      exc_cause_i    = 5'd2;
      exc_pc_i       = 32'h0000_0500;
      tick();
      exc_valid_i = 1'b0;
      tick();
      check("abort_in_flush", {63'd0, flush_o}, 64'd1);
      check("abort_no_we_yet", {63'd0, csr_we_o}, 64'd0);
      rst_i = 1'b1;
      tick();
      check("abort_busy", {63'd0, busy_o}, 64'd0);
      check("abort_flush", {63'd0, flush_o}, 64'd0);
      check("abort_mip", {32'd0, mip_o}, 64'd0);
      check("abort_redirect_pc", {32'd0, redirect_pc_o}, 64'd0);
      rst_i          = 1'b0;
      local_irq_i[2] = 1'b0;
      pipe_idle_i    = 1'b1;
      repeat (4) tick();
      check("abort_still_idle", {63'd0, busy_o}, 64'd0);
      check("sb_drained", {32'd0, sb_q.size()}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beta_trap_sequencer.md
# beta_trap_sequencer

Parametrised, multi-cycle trap sequencer for the beta core; the successor to the single-cycle trap control unit. Registers interrupt pending state for the standard machine interrupts plus `NumLocalIrq` platform-local lines, each local line level- or edge-sensitive. Arbitrates exceptions, interrupts and MRET. Drives a FLUSH → COMMIT → REDIRECT handshake between the execution control unit, the CSR file and fetch.

## Interface
- `DataWidth`, 32: data/CSR width.
- `AddrWidth`, 32: address width.
- `NumLocalIrq`, 16: local interrupt lines (0..16); line i has cause 16+i.
- `LocalIrqEdge`, '0: NumLocalIrq-bit mask; 1 = edge-sensitive line, 0 = level-sensitive.
- Reset is synchronous and active-high; the module has one clock.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `priv_lvl_i`  in  1  current privilege (1 = M, 0 = U).
- `exc_valid_i`  in  1  exception from the pipe.
- `exc_cause_i`  in  5  exception cause code.
- `exc_tval_i`  in  DataWidth  fault instruction or address.
- `exc_pc_i`  in  AddrWidth  PC of the faulting instruction.
- `mret_i`  in  1  MRET retiring.
- `irq_allow_i`  in  1  pipe is at an interruptible boundary.
- `boundary_pc_i`  in  AddrWidth  next PC to resume after an interrupt.
- `sw_irq_i`, `tim_irq_i`, `ext_irq_i`  in  1 each  standard interrupt lines.
- `local_irq_i`  in  NumLocalIrq  local interrupt lines.
- `irq_clear_i`  in  NumLocalIrq  software clear pulses for edge-mode pending bits.
- `mstatus_mie_i`, `mstatus_mpie_i`, `mstatus_mpp_i`  in  1 each  current status fields.
- `mie_en_i`  in  16+NumLocalIrq  per-cause interrupt enable (mie CSR).
- `mtvec_i`  in  AddrWidth  trap vector CSR.
- `mepc_i`  in  AddrWidth  current mepc.
- `pipe_idle_i`  in  1  pipe drained after flush.
- `flush_o`  out  1  squash the pipe.
- `csr_we_o`  out  1  one-cycle CSR write strobe.
- `mcause_o`  out  DataWidth  bit DataWidth-1 = interrupt; bits 4:0 = cause.
- `mepc_o`, `mtval_o`  out  AddrWidth / DataWidth  values to write.
- `trap_state_o`  out  3  {MIE, MPIE, MPP}.
- `priv_o`  out  1  new privilege.
- `mip_o`  out  16+NumLocalIrq  registered pending bits.
- `redirect_valid_o`  out  1  redirect request to fetch.
- `redirect_pc_o`  out  AddrWidth  redirect target.
- `redirect_ready_i`  in  1  fetch accepts the redirect.
- `busy_o`  out  1  FSM is not IDLE.

## Operation
- Pending registers:
  - Bits 3, 7, 11 (MSI, MTI, MEI) register their inputs every cycle.
  - Level-mode local bit = registered input.
  - Edge-mode local bit is set on a 0→1 input edge. It is cleared by `irq_clear_i` or by the COMMIT of that cause. Set wins over a same-cycle clear.
- Taken interrupt = `mstatus_mie_i & irq_allow_i & |(mip_o & mie_en_i)`.
- Priority order:
  - `mret_i` > exception > MEI > MSI > MTI.
  - Then local lines, highest index first.
- FSM states:
  - IDLE: on an event, capture cause, tval, epc and kind into registers, then go to FLUSH. Captured epc: `exc_pc_i` for an exception, `boundary_pc_i` for an interrupt.
  - FLUSH: `flush_o`=1. Stay until `pipe_idle_i`, then go to COMMIT.
  - COMMIT: `csr_we_o`=1 for exactly one cycle, then go to REDIRECT.
  - REDIRECT: `redirect_valid_o`=1 with a stable PC until `redirect_ready_i`, then go to IDLE.
- Trap commit:
  - `trap_state_o` = {0, `mstatus_mie_i`, `priv_lvl_i`}; `priv_o`=1.
  - Exception: tval = `exc_tval_i`. Interrupt: tval = 0.
- MRET commit:
  - `trap_state_o` = {`mstatus_mpie_i`, 1, 0}; `priv_o` = `mstatus_mpp_i`.
  - `mepc_o` = `mepc_i`; redirect target = `mepc_i`; no mcause/mtval update.
- Redirect target for a trap:
  - `{mtvec_i[AddrWidth-1:2],2'b00}`.
  - If vectored (`mtvec_i[1:0]`=01) and the trap is an interrupt, add cause×4, computed modulo 2^AddrWidth.
- Events arriving while not IDLE are ignored; the pipe is flushing. Pending bits keep updating in all states.

## Timing
- Reset: all outputs and pending bits are 0 and the FSM is IDLE in the cycle after `rst_i` is sampled high. A reset mid-sequence aborts with no CSR write.
- Minimum latency with `pipe_idle_i` already high:
  - Event sampled at edge N.
  - `flush_o` high in cycle N+1.
  - `csr_we_o` high in cycle N+2.
  - `redirect_valid_o` high from cycle N+3.
- `mcause_o`, `mepc_o`, `mtval_o`, `trap_state_o` and `priv_o` are registered. They hold from COMMIT through REDIRECT and are 0 otherwise.
- An interrupt line asserted at edge N is visible in `mip_o` at N+1 and can be taken at N+1 at the earliest.

## Configuration
- `BETA_TRAP_VECTORED_EN`:
  - Defined: vectored mode is supported as above.
  - Undefined: `mtvec_i[1:0]` is ignored and every trap goes to the base address.

## Structure
- `beta_trap_pkg` holds:
  - The FSM state enum (IDLE, FLUSH, COMMIT, REDIRECT).
  - Cause constants MSW_INT=3, MTIM_INT=7, MEXT_INT=11, LOCAL_INT_BASE=16.
  - The exception cause constants.
- Sub-module `beta_irq_prio_encoder`: combinational; takes the masked pending vector and returns valid plus a 5-bit cause.

## Test plan
- Illegal-instruction exception: `exc_valid_i`, cause 2, tval 0x00000013, pc 0x100, `pipe_idle_i`=1 → `csr_we_o` at N+2 with mcause 2, mepc 0x100; redirect to base 0x8000 at N+3.
- Vectored MEI: `mtvec_i`=0x8001, MIE=1, `ext_irq_i`=1 → mcause 0x8000000B; redirect 0x802C (direct-only build: 0x8000).
- Priority: exception and MEI pending in the same cycle → exception taken; MEI taken after MRET returns with MIE=1.
- Edge local line 5: pulse `local_irq_i[5]` for one cycle with enable off → `mip_o[21]` stays 1. Enable it → mcause 0x80000015; bit cleared at COMMIT.
- MRET with MPIE=1, MPP=0, mepc 0x200 → trap_state 3'b110, `priv_o`=0; redirect 0x200 held 4 cycles while `redirect_ready_i`=0.
- Reset in FLUSH → no `csr_we_o`; all outputs 0; `busy_o`=0 next cycle.
